// File: rtl/riscv_loader_pkg.sv
// Shared types and constants for the boot-time IMEM loader.
// The LEN header and each instruction word have the same byte width, so one assembler serves both.
package riscv_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CKSUM,
    DONE,
    ERR
  } loader_state_t;

  localparam int LDR_HDR_BYTES  = 4;
  localparam int LDR_WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Assembles little-endian 32-bit words from a byte stream; word/word_valid are combinational on the 4th byte.
// Zero latency on the completing byte; never back-pressures (the caller gates byte_valid).
module byte_assembler
  import riscv_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] low_bytes;

  assign word_valid = byte_valid && (lane == 2'(LDR_WORD_BYTES - 1));
  assign word       = {byte_data, low_bytes};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane      <= 2'd0;
      low_bytes <= 24'd0;
    end else if (clear) begin
      lane      <= 2'd0;
      low_bytes <= 24'd0;
    end else if (byte_valid) begin
      lane <= lane + 2'd1;
      // Lane 3 is never stored: it goes straight out on word.
      case (lane)
        2'd0:    low_bytes[7:0]   <= byte_data;
        2'd1:    low_bytes[15:8]  <= byte_data;
        2'd2:    low_bytes[23:16] <= byte_data;
        default: low_bytes        <= low_bytes;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> sequential IMEM writes from address 0, core held in reset until the image is done.
// Writes appear one cycle after the completing byte; rx_ready decodes from state. Option: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import riscv_loader_pkg::*;
#(
  parameter int unsigned DEPTH_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst_n,
  output logic        done,
  output logic        error
);

  localparam logic [DEPTH_W:0] IDX_ONE   = 1;
  localparam logic [31:0]      MAX_WORDS = 32'd1 << DEPTH_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t TAIL_STATE = CKSUM;
`else
  localparam loader_state_t TAIL_STATE = DONE;
`endif

  loader_state_t    state;
  logic [DEPTH_W:0] word_idx;
  logic [DEPTH_W:0] word_cnt;
  logic [DEPTH_W:0] word_idx_nxt;
  logic             rx_fire;
  logic             asm_valid;
  logic             word_valid;
  logic [31:0]      word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       cksum;
`endif

  assign rx_ready     = (state == LEN) || (state == DATA) || (state == CKSUM);
  assign rx_fire      = rx_valid && rx_ready;
  assign asm_valid    = rx_fire && ((state == LEN) || (state == DATA));
  assign word_idx_nxt = word_idx + IDX_ONE;

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == IDLE),
    .byte_valid (asm_valid),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      word_idx   <= '0;
      word_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= 32'd0;
      imem_wdata <= 32'd0;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      cksum      <= 8'd0;
`endif
    end else begin
      imem_we <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (rx_fire) cksum <= cksum ^ rx_data;
`endif
      case (state)
        IDLE: begin
          word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          cksum    <= 8'd0;
`endif
          state    <= LEN;
        end
        LEN: begin
          if (word_valid) begin
            word_cnt <= word[DEPTH_W:0];
            // A single compare also rejects any set bit above DEPTH_W.
            if (word > MAX_WORDS) begin
              state <= ERR;
              error <= 1'b1;
            end else if (word == 32'd0) begin
              state <= TAIL_STATE;
              if (TAIL_STATE == DONE) begin
                core_rst_n <= 1'b1;
                done       <= 1'b1;
              end
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (word_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= 32'(word_idx) << 2;
            imem_wdata <= word;
            word_idx   <= word_idx_nxt;
            if (word_idx_nxt == word_cnt) begin
              state <= TAIL_STATE;
              if (TAIL_STATE == DONE) begin
                core_rst_n <= 1'b1;
                done       <= 1'b1;
              end
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CKSUM: begin
          if (rx_fire) begin
            if (rx_data == cksum) begin
              state      <= DONE;
              core_rst_n <= 1'b1;
              done       <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          if (reload) begin
            state      <= IDLE;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
          end
        end
        ERR: begin
          if (reload) begin
            state <= IDLE;
            error <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; expected IMEM writes are queued at stimulus time and popped by a monitor.
module tb_imem_loader;

  localparam int DEPTH_W = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        reload = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        done;
  logic        error;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  img[$];
  logic [31:0] words[$];
  logic [63:0] mon_e;

  imem_loader #(.DEPTH_W(DEPTH_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_write: got addr 0x%08h data 0x%08h, expected no write", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", imem_addr, mon_e[63:32]);
        chk("wr_data", imem_wdata, mon_e[31:0]);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: got rx_ready=0 for 20 cycles, expected 1");
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic build_image(input logic [31:0] n_hdr, input bit push_exp);
    logic [7:0] x;
    img.delete();
    x = 8'd0;
    for (int i = 0; i < 4; i++) img.push_back(n_hdr[8*i +: 8]);
    foreach (words[i]) for (int b = 0; b < 4; b++) img.push_back(words[i][8*b +: 8]);
    foreach (img[i]) x ^= img[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
    img.push_back(x);
`endif
    if (push_exp) foreach (words[i]) exp_q.push_back({32'(i) << 2, words[i]});
  endtask

  task automatic send_img(input int max_gap);
    foreach (img[i]) send_byte(img[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("reload_error", 32'(error), 32'd0);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd1);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, 32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic send_hdr_expect_err(input logic [31:0] n_hdr, input string tag);
    for (int i = 0; i < 4; i++) send_byte(n_hdr[8*i +: 8], 0);
    chk({tag, "_error"}, 32'(error), 32'd1);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;

    // Two-word image, back to back.
    words = '{32'h0010_0513, 32'h0020_0593};
    build_image(32'd2, 1'b1);
    send_img(0);
    chk_done("two_word");
    @(negedge clk);
    chk("two_word_drained", 32'(exp_q.size()), 32'd0);
    chk("two_word_hold", 32'(done), 32'd1);

    // Empty image: no writes, done right after the last byte.
    pulse_reload();
    words.delete();
    build_image(32'd0, 1'b1);
    send_img(0);
    chk_done("empty");

    // Oversize count and a count with a high bit set.
    pulse_reload();
    send_hdr_expect_err((32'd1 << DEPTH_W) + 32'd1, "oversize");
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("err_no_accept", 32'(rx_ready), 32'd0);
    rx_valid = 1'b0;
    pulse_reload();
    send_hdr_expect_err(32'h0001_0000, "upper_bit");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Corrupted checksum: data still written, core not released.
    pulse_reload();
    words = '{32'h0010_0513, 32'h0020_0593};
    build_image(32'd2, 1'b1);
    img[img.size() - 1] = img[img.size() - 1] ^ 8'hFF;
    send_img(0);
    chk("bad_cksum_error", 32'(error), 32'd1);
    chk("bad_cksum_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("bad_cksum_done", 32'(done), 32'd0);
`endif

    // Same image with random gaps.
    pulse_reload();
    words = '{32'h0010_0513, 32'h0020_0593};
    build_image(32'd2, 1'b1);
    send_img(5);
    chk_done("gapped");

    // Maximum-size image: last write lands at the top word address.
    pulse_reload();
    words.delete();
    for (int i = 0; i < (1 << DEPTH_W); i++) words.push_back({16'(i), ~16'(i)} ^ 32'h0000_0013);
    build_image(32'd1 << DEPTH_W, 1'b1);
    send_img(0);
    chk_done("max_size");

    // Reset mid-image after 6 data bytes, then a fresh load from address 0.
    pulse_reload();
    words = '{32'h1111_2222, 32'h3333_4444};
    build_image(32'd2, 1'b0);
    exp_q.push_back({32'd0, 32'h1111_2222});
    for (int i = 0; i < 10; i++) send_byte(img[i], 0);
    rst = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    words = '{32'hDEAD_BEEF};
    build_image(32'd1, 1'b1);
    send_img(0);
    chk_done("after_rst");

    @(negedge clk);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
